// File: rtl/mul_rob_writeback.sv
// mul_rob_writeback: buffers multiply results in a small FIFO and writes them to the ROB port
// Inputs: M5 result (valid, instruction_type, pc, aluResult, rob_id) and ROB grant rob_wr_ready.
// Outputs: stall back to M1-M5, rob_wr_* request/payload of the FIFO head, count occupancy.
// Optional: define MUL_WB_BYPASS_EN to forward an input straight to the ROB port when empty.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif
module mul_rob_writeback #(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
  input  logic [WORD_SIZE-1:0]       pc,
  input  logic [WORD_SIZE-1:0]       aluResult,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  output logic                       stall,
  output logic                       rob_wr_valid,
  input  logic                       rob_wr_ready,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id,
  output logic [WORD_SIZE-1:0]       rob_wr_value,
  output logic [WORD_SIZE-1:0]       rob_wr_pc,
  output logic [INSTR_TYPE_SZ-1:0]   rob_wr_type,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = INSTR_TYPE_SZ + 2 * WORD_SIZE + ROB_ENTRY_WIDTH;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic [PW-1:0] in_word, out_word;
  logic push, pop;
  assign in_word = {instruction_type, pc, aluResult, rob_id};
  assign stall = count_q == FULL;
  assign count = count_q;
`ifdef MUL_WB_BYPASS_EN
  // an empty FIFO with a granted port hands the input straight through instead of storing it
  logic bypass;
  assign bypass = count_q == '0 && valid && rob_wr_ready;
  assign push = valid && !stall && !bypass;
  assign pop = count_q != '0 && rob_wr_ready;
  assign rob_wr_valid = count_q != '0 || valid;
  assign out_word = count_q == '0 ? in_word : mem_q[rd_ptr_q];
`else
  assign push = valid && !stall;
  assign pop = rob_wr_valid && rob_wr_ready;
  assign rob_wr_valid = count_q != '0;
  assign out_word = mem_q[rd_ptr_q];
`endif
  assign {rob_wr_type, rob_wr_pc, rob_wr_value, rob_wr_id} = out_word;
  always_comb count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= in_word;
      wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_mul_rob_writeback.sv
// tb_mul_rob_writeback: randomized and directed checks of mul_rob_writeback against a queue model
module tb_mul_rob_writeback;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [3:0]  typ;
    logic [31:0] pc;
    logic [31:0] val;
    logic [3:0]  id;
  } item_t;
  logic clk = 0, reset = 1, valid = 0, rob_wr_ready = 0, stall, rob_wr_valid;
  logic [3:0] instruction_type = 0, rob_id = 0, rob_wr_id, rob_wr_type;
  logic [31:0] pc = 0, aluResult = 0, rob_wr_value, rob_wr_pc;
  logic [2:0] count;
  int checks = 0, errors = 0;
  item_t model_q[$];
  logic [3:0] emitted[$];
  always #5 clk = ~clk;
  mul_rob_writeback #(.WORD_SIZE(32), .INSTR_TYPE_SZ(4), .ROB_ENTRY_WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid(valid), .instruction_type(instruction_type), .pc(pc),
    .aluResult(aluResult), .rob_id(rob_id), .stall(stall), .rob_wr_valid(rob_wr_valid),
    .rob_wr_ready(rob_wr_ready), .rob_wr_id(rob_wr_id), .rob_wr_value(rob_wr_value),
    .rob_wr_pc(rob_wr_pc), .rob_wr_type(rob_wr_type), .count(count));
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask
  // one clock: drive, check model against outputs mid-cycle, then advance model at the edge
  task automatic step(input logic rst, input logic v, input item_t it, input logic rdy, output logic acc);
    logic do_push, do_pop;
    reset = rst; valid = v; rob_wr_ready = rdy;
    instruction_type = it.typ; pc = it.pc; aluResult = it.val; rob_id = it.id;
    @(negedge clk);
    if (!rst) begin
      chk("count", count, 64'(model_q.size()));
      chk("stall", stall, model_q.size() == DEPTH);
      chk("wr_valid", rob_wr_valid, model_q.size() != 0);
      if (model_q.size() != 0) begin
        chk("wr_id", rob_wr_id, model_q[0].id);
        chk("wr_value", rob_wr_value, model_q[0].val);
        chk("wr_pc", rob_wr_pc, model_q[0].pc);
        chk("wr_type", rob_wr_type, model_q[0].typ);
      end
    end
    do_push = !rst && v && model_q.size() < DEPTH;
    do_pop = !rst && rdy && model_q.size() != 0;
    @(posedge clk);
    if (rst) model_q.delete();
    else begin
      if (do_pop) emitted.push_back(model_q.pop_front().id);
      if (do_push) model_q.push_back(it);
    end
    acc = do_push;
    #1;
  endtask
  function automatic item_t mk(input logic [3:0] id);
    mk.typ = 4'($urandom); mk.pc = $urandom; mk.val = $urandom; mk.id = id;
  endfunction
  initial begin
    logic acc;
    item_t it, pend;
    logic has_pend;
    int n;
    it = '0;
    step(1, 0, it, 0, acc);
    step(1, 0, it, 0, acc);
    chk("rst_count", count, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valid", rob_wr_valid, 0);
    for (int i = 0; i < 10; i++) step(0, 0, it, 0, acc);
    chk("idle_valid", rob_wr_valid, 0);
    it = '{typ: 4'h2, pc: 32'h100, val: 32'h1234, id: 4'd5};
    step(0, 1, it, 1, acc);
    chk("single_valid", rob_wr_valid, 1);
    chk("single_id", rob_wr_id, 5);
    chk("single_value", rob_wr_value, 32'h1234);
    step(0, 0, it, 1, acc);
    chk("single_drain", count, 0);
    emitted.delete();
    for (int i = 1; i <= 4; i++) step(0, 1, mk(4'(i)), 0, acc);
    chk("fill_stall", stall, 1);
    it = mk(4'd6);
    step(0, 1, it, 0, acc);
    chk("fill_no_accept", acc, 0);
    step(0, 1, it, 1, acc);
    chk("full_pop_only", acc, 0);
    chk("full_pop_count", count, 3);
    step(0, 1, it, 1, acc);
    chk("pop_push_acc", acc, 1);
    chk("pop_push_count", count, 3);
    for (int i = 0; i < 6; i++) step(0, 0, it, 1, acc);
    chk("fill_order_n", emitted.size(), 5);
    for (int i = 0; i < 5 && i < emitted.size(); i++)
      chk("fill_order", emitted[i], (i == 4) ? 6 : i + 1);
    emitted.delete();
    n = 0; has_pend = 0;
    for (int c = 0; c < 200 && (n < 12 || has_pend); c++) begin
      if (!has_pend && n < 12) begin pend = mk(4'(n)); has_pend = 1; n++; end
      step(0, has_pend, pend, c[0], acc);
      if (acc) has_pend = 0;
    end
    for (int i = 0; i < 8; i++) step(0, 0, it, 1, acc);
    chk("wrap_n", emitted.size(), 12);
    for (int i = 0; i < 12 && i < emitted.size(); i++) chk("wrap_order", emitted[i], i);
    for (int i = 13; i <= 15; i++) step(0, 1, mk(4'(i)), 0, acc);
    chk("pre_rst_count", count, 3);
    emitted.delete();
    step(1, 1, mk(4'd9), 1, acc);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", rob_wr_valid, 0);
    chk("mid_rst_stall", stall, 0);
    for (int i = 0; i < 4; i++) step(0, 0, it, 1, acc);
    chk("mid_rst_emitted", emitted.size(), 0);
    has_pend = 0;
    for (int c = 0; c < 400; c++) begin
      if (!has_pend && $urandom_range(0, 2) != 0) begin pend = mk(4'($urandom)); has_pend = 1; end
      if ($urandom_range(0, 39) == 0) begin
        step(1, has_pend, pend, 1'($urandom), acc);
        has_pend = 0;
      end else begin
        step(0, has_pend, pend, 1'($urandom), acc);
        if (acc) has_pend = 0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
